// File: rtl/load_writeback_unit.sv
// Register-file writer: merges ALU results with in-order load responses, formats
// load data and publishes a mask of registers with loads still in flight.
module load_writeback_unit #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid_in,
    input  logic [4:0]  alu_rd_in,
    input  logic [31:0] alu_data_in,
    input  logic        load_issue_in,
    input  logic [4:0]  load_rd_in,
    input  logic [2:0]  load_funct3_in,
    input  logic [1:0]  load_offset_in,
    output logic        load_full_out,
    input  logic        mem_resp_valid_in,
    input  logic [31:0] mem_resp_data_in,
    output logic        mem_resp_ready_out,
    output logic        write_enable_out,
    output logic [4:0]  rd_sel_out,
    output logic [31:0] write_data_out,
    output logic [31:0] pending_mask_out
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [4:0]       rd_q    [DEPTH];
    logic [4:0]       rd_d    [DEPTH];
    logic [2:0]       f3_q    [DEPTH];
    logic [2:0]       f3_d    [DEPTH];
    logic [1:0]       off_q   [DEPTH];
    logic [1:0]       off_d   [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             we_q, we_d;
    logic [4:0]       rd_sel_q, rd_sel_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      mask_q, mask_d;
    logic             push_s, pop_s;

    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (f3)
            3'b000:  format_load = {{24{b[7]}}, b};
            3'b100:  format_load = {24'h000000, b};
            3'b001:  format_load = {{16{h[15]}}, h};
            3'b101:  format_load = {16'h0000, h};
            default: format_load = word;
        endcase
    endfunction

    assign load_full_out      = (count_q == FULL_CNT);
    assign mem_resp_ready_out = (count_q != '0) && !alu_valid_in;
    assign push_s             = load_issue_in && !load_full_out;
    assign pop_s              = mem_resp_valid_in && mem_resp_ready_out;

    // Next-state: queue update, writeback selection (ALU wins) and pending mask
    always_comb begin
        rd_d     = rd_q;
        f3_d     = f3_q;
        off_d    = off_q;
        valid_d  = valid_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
        we_d     = 1'b0;
        rd_sel_d = rd_sel_q;
        data_d   = data_q;
        mask_d   = 32'h0000_0000;

        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end

        if (push_s) begin
            rd_d[tail_q]    = load_rd_in;
            f3_d[tail_q]    = load_funct3_in;
            off_d[tail_q]   = load_offset_in;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end

        if (alu_valid_in) begin
            we_d     = (alu_rd_in != 5'd0);
            rd_sel_d = alu_rd_in;
            data_d   = alu_data_in;
        end else if (pop_s) begin
            we_d     = (rd_q[head_q] != 5'd0);
            rd_sel_d = rd_q[head_q];
            data_d   = format_load(f3_q[head_q], off_q[head_q], mem_resp_data_in);
        end else begin
            we_d = 1'b0;
        end

        // Duplicate destinations simply OR together; x0 never counts as pending
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i] && (rd_d[i] != 5'd0)) begin
                mask_d[rd_d[i]] = 1'b1;
            end else begin
                mask_d = mask_d;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]  <= 5'd0;
                f3_q[i]  <= 3'd0;
                off_q[i] <= 2'd0;
            end
            valid_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            rd_sel_q <= 5'd0;
            data_q   <= 32'h0000_0000;
            mask_q   <= 32'h0000_0000;
        end else begin
            rd_q     <= rd_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            we_q     <= we_d;
            rd_sel_q <= rd_sel_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
        end
    end

    assign write_enable_out = we_q;
    assign rd_sel_out       = rd_sel_q;
    assign write_data_out   = data_q;
    assign pending_mask_out = mask_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit; expected writes go into a scoreboard
// queue that a negedge monitor drains whenever the DUT asserts a write.
module tb_load_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid_in;
    logic [4:0]  alu_rd_in;
    logic [31:0] alu_data_in;
    logic        load_issue_in;
    logic [4:0]  load_rd_in;
    logic [2:0]  load_funct3_in;
    logic [1:0]  load_offset_in;
    logic        load_full_out;
    logic        mem_resp_valid_in;
    logic [31:0] mem_resp_data_in;
    logic        mem_resp_ready_out;
    logic        write_enable_out;
    logic [4:0]  rd_sel_out;
    logic [31:0] write_data_out;
    logic [31:0] pending_mask_out;

    int errors = 0;
    int checks = 0;
    logic [36:0] sbq [$];

    always #5 clk = ~clk;

    load_writeback_unit #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid_in(alu_valid_in), .alu_rd_in(alu_rd_in), .alu_data_in(alu_data_in),
        .load_issue_in(load_issue_in), .load_rd_in(load_rd_in),
        .load_funct3_in(load_funct3_in), .load_offset_in(load_offset_in),
        .load_full_out(load_full_out),
        .mem_resp_valid_in(mem_resp_valid_in), .mem_resp_data_in(mem_resp_data_in),
        .mem_resp_ready_out(mem_resp_ready_out),
        .write_enable_out(write_enable_out), .rd_sel_out(rd_sel_out),
        .write_data_out(write_data_out), .pending_mask_out(pending_mask_out)
    );

    // Monitor: every observed write must match the oldest expected write
    always @(negedge clk) begin
        if (write_enable_out) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write",
                         rd_sel_out, write_data_out);
            end else begin
                logic [36:0] e;
                e = sbq.pop_front();
                if ({rd_sel_out, write_data_out} !== e) begin
                    errors++;
                    $display("FAIL write: got rd=%0d data=%h, expected rd=%0d data=%h",
                             rd_sel_out, write_data_out, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        alu_valid_in      = 1'b0;
        load_issue_in     = 1'b0;
        mem_resp_valid_in = 1'b0;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        sbq.push_back({rd, data});
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        load_issue_in  = 1'b1;
        load_rd_in     = rd;
        load_funct3_in = f3;
        load_offset_in = off;
    endtask

    task automatic respond(input logic [31:0] word);
        mem_resp_valid_in = 1'b1;
        mem_resp_data_in  = word;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] data);
        alu_valid_in = 1'b1;
        alu_rd_in    = rd;
        alu_data_in  = data;
    endtask

    // One load followed by its response, with the formatted result hand-computed
    task automatic load_one(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] word, input logic [31:0] exp);
        issue(rd, f3, off);
        tick();
        respond(word);
        #1;
        chk("ready_single", {31'd0, mem_resp_ready_out}, 32'd1);
        expect_wr(rd, exp);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        alu_valid_in = 1'b0; alu_rd_in = 5'd0; alu_data_in = 32'h0;
        load_issue_in = 1'b0; load_rd_in = 5'd0; load_funct3_in = 3'd0; load_offset_in = 2'd0;
        mem_resp_valid_in = 1'b0; mem_resp_data_in = 32'h0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_we",    {31'd0, write_enable_out}, 32'd0);
        chk("rst_rd",    {27'd0, rd_sel_out}, 32'd0);
        chk("rst_data",  write_data_out, 32'h0);
        chk("rst_mask",  pending_mask_out, 32'h0);
        chk("rst_full",  {31'd0, load_full_out}, 32'd0);
        chk("rst_ready", {31'd0, mem_resp_ready_out}, 32'd0);

        // ALU writes, including one to x0 that must not write
        alu(5'd5, 32'h1234_5678); expect_wr(5'd5, 32'h1234_5678); tick();
        chk("alu_rd", {27'd0, rd_sel_out}, 32'd5);
        alu(5'd0, 32'hDEAD_BEEF); tick();
        chk("alu_x0_we", {31'd0, write_enable_out}, 32'd0);
        tick();
        chk("hold_data", write_data_out, 32'hDEAD_BEEF);

        // Load formatting
        load_one(5'd3, 3'b000, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF);
        load_one(5'd6, 3'b100, 2'd3, 32'h80FF_7F01, 32'h0000_0080);
        load_one(5'd7, 3'b001, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF);
        load_one(5'd8, 3'b101, 2'd0, 32'h80FF_7F01, 32'h0000_7F01);
        load_one(5'd9, 3'b010, 2'd1, 32'h80FF_7F01, 32'h80FF_7F01);

        // Fill to full, ignored fifth issue, then drain
        issue(5'd1, 3'b010, 2'd0); tick();
        issue(5'd2, 3'b010, 2'd0); tick();
        issue(5'd3, 3'b010, 2'd0); tick();
        chk("full_at3", {31'd0, load_full_out}, 32'd0);
        issue(5'd1, 3'b010, 2'd0); tick();
        chk("full", {31'd0, load_full_out}, 32'd1);
        chk("mask_full", pending_mask_out, 32'h0000_000E);
        issue(5'd7, 3'b010, 2'd0); tick();
        chk("mask_5th", pending_mask_out, 32'h0000_000E);
        respond(32'h1111_1111); expect_wr(5'd1, 32'h1111_1111); tick();
        chk("full_after_pop", {31'd0, load_full_out}, 32'd0);
        respond(32'h2222_2222); expect_wr(5'd2, 32'h2222_2222); tick();
        chk("mask_2pops", pending_mask_out, 32'h0000_000A);
        respond(32'h3333_3333); expect_wr(5'd3, 32'h3333_3333); tick();
        respond(32'h4444_4444); expect_wr(5'd1, 32'h4444_4444); tick();
        chk("mask_drained", pending_mask_out, 32'h0);
        respond(32'h5555_5555); #1;
        chk("ready_empty", {31'd0, mem_resp_ready_out}, 32'd0);
        tick();

        // ALU / response conflict
        issue(5'd9, 3'b010, 2'd0); tick();
        alu(5'd4, 32'hA5A5_A5A5); respond(32'hCAFE_F00D); #1;
        chk("ready_conflict", {31'd0, mem_resp_ready_out}, 32'd0);
        expect_wr(5'd4, 32'hA5A5_A5A5); tick();
        respond(32'hCAFE_F00D); #1;
        chk("ready_after", {31'd0, mem_resp_ready_out}, 32'd1);
        expect_wr(5'd9, 32'hCAFE_F00D); tick();

        // Load to x0 consumes its response silently
        issue(5'd0, 3'b010, 2'd0); tick();
        chk("mask_x0", pending_mask_out, 32'h0);
        respond(32'h0BAD_0BAD); tick();
        chk("x0_we", {31'd0, write_enable_out}, 32'd0);

        // Simultaneous push/pop at count 2
        issue(5'd10, 3'b010, 2'd0); tick();
        issue(5'd11, 3'b010, 2'd0); tick();
        issue(5'd12, 3'b010, 2'd0); respond(32'h0A0A_0A0A);
        expect_wr(5'd10, 32'h0A0A_0A0A); tick();
        chk("mask_pushpop", pending_mask_out, 32'h0000_1800);
        respond(32'h0B0B_0B0B); expect_wr(5'd11, 32'h0B0B_0B0B); tick();
        respond(32'h0C0C_0C0C); expect_wr(5'd12, 32'h0C0C_0C0C); tick();
        chk("mask_pp_done", pending_mask_out, 32'h0);

        // Reset with three loads outstanding
        issue(5'd13, 3'b010, 2'd0); tick();
        issue(5'd14, 3'b010, 2'd0); tick();
        issue(5'd15, 3'b010, 2'd0); tick();
        chk("mask_pre_rst", pending_mask_out, 32'h0000_E000);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mask_post_rst", pending_mask_out, 32'h0);
        chk("full_post_rst", {31'd0, load_full_out}, 32'd0);
        respond(32'h7777_7777); #1;
        chk("ready_post_rst", {31'd0, mem_resp_ready_out}, 32'd0);
        tick();
        chk("we_post_rst", {31'd0, write_enable_out}, 32'd0);
        tick(); tick();

        chk("sb_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
